// File: rtl/hash_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hash_pkg
//  Description : Shared constants and types for the byte-serial S-box hash
//                engine: initial value, framing bytes, default round count,
//                FSM state encoding and a byte-rotate helper.
//  Revision    : 1.0  initial release
// ============================================================================
package hash_pkg;

    localparam int DEFAULT_ROUNDS = 32;

    localparam logic [7:0] START_BYTE = 8'hFF;
    localparam logic [7:0] END_BYTE   = 8'h00;

    // Initial value for h[0..7]
    localparam logic [7:0] IV [0:7] = '{8'h34, 8'h55, 8'h0F, 8'h14,
                                        8'hAA, 8'h38, 8'h42, 8'h57};

    // FSM state encoding
    typedef logic [1:0] hash_state_t;
    localparam hash_state_t ST_IDLE      = 2'd0;
    localparam hash_state_t ST_WAIT_BYTE = 2'd1;
    localparam hash_state_t ST_ABSORB    = 2'd2;

    // Rotate an 8-bit value left by n (n = 0 leaves it unchanged).
    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
        return (v << n) | (v >> (4'd8 - {1'b0, n}));
    endfunction

endpackage : hash_pkg
`default_nettype wire

// File: rtl/hash_aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Purely combinational FIPS-197 forward S-box.
//  Ports       : in_byte  [7:0] in  - substitution input
//                out_byte [7:0] out - S-box output
//  Revision    : 1.0  initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Row 0 of the table sits in the most significant bits, so entry x lives
    // at bit offset (255 - x) * 8, which is simply {~x, 3'b000}.
    localparam logic [2047:0] c_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_offset;

    assign w_offset = {~in_byte, 3'b000};
    assign out_byte = c_table[w_offset +: 8];

endmodule : aes_sbox
`default_nettype wire

// File: rtl/hash.sv
`default_nettype none
// ============================================================================
//  Module      : hash
//  Description : Lightweight 64-bit hash engine built on the AES S-box.
//                Absorbs a framed byte stream (0xFF, payload..., 0x00); each
//                payload byte is mixed into an 8-byte state over ROUNDS
//                single-cycle rounds. The terminator publishes the digest.
//  Parameters  : ROUNDS - compression rounds per absorbed byte (>= 1)
//  Ports       : clk        in       - system clock, rising edge
//                reset_l    in       - asynchronous reset, active HIGH
//                m          in  [7:0]- message byte
//                m_valid    in       - one-cycle strobe qualifying m
//                hash_ready out      - out holds the last completed digest
//                out        out [63:0]- digest, out[63:56] = h[0]
//  Build macro : HASH_LEN_FINAL_EN - absorb an 8-bit payload length as an
//                extra byte on the terminator before publishing the digest.
//  Revision    : 1.0  initial release
// ============================================================================
module hash
    import hash_pkg::*;
#(
    parameter int ROUNDS = DEFAULT_ROUNDS
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic [7:0]  m,
    input  logic        m_valid,
    output logic        hash_ready,
    output logic [63:0] out
);

    localparam int             c_cw   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(ROUNDS - 1);

    hash_state_t     r_state;
    logic [7:0]      r_h [0:7];
    logic [7:0]      r_b;
    logic [c_cw-1:0] r_count;
    logic            next_byte;
`ifdef HASH_LEN_FINAL_EN
    logic [7:0]      r_len;
    logic            r_final;
`endif

    logic [7:0]  w_round;
    logic [7:0]  w_sbox_in  [0:7];
    logic [7:0]  w_sbox_out [0:7];
    logic [7:0]  w_h_next   [0:7];
    logic [63:0] w_h_packed;
    logic        w_accept;

    // Bytes arriving while a byte is still being compressed are dropped.
    assign w_accept = m_valid & ~next_byte;
    assign w_round  = 8'(r_count);

    // All eight lanes read the old state, so one round is fully parallel.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign w_sbox_in[gi] = r_h[(gi + 1) % 8] ^ r_b ^ w_round;

            aes_sbox u_sbox (
                .in_byte  (w_sbox_in[gi]),
                .out_byte (w_sbox_out[gi])
            );

            assign w_h_next[gi] = r_h[gi] ^ rotl8(w_sbox_out[gi], 3'(gi));
            assign w_h_packed[63 - 8*gi -: 8] = r_h[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset_l) begin
        if (reset_l) begin
            r_state    <= ST_IDLE;
            for (int i = 0; i < 8; i++) r_h[i] <= IV[i];
            r_b        <= 8'h00;
            r_count    <= '0;
            next_byte  <= 1'b0;
            hash_ready <= 1'b0;
            out        <= 64'h0;
`ifdef HASH_LEN_FINAL_EN
            r_len      <= 8'h00;
            r_final    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef HASH_LEN_FINAL_EN
                    // The length byte has just been compressed: publish now.
                    // Any byte strobed in this single cycle is dropped.
                    if (r_final) begin
                        out        <= w_h_packed;
                        hash_ready <= 1'b1;
                        r_final    <= 1'b0;
                    end else
`endif
                    if (w_accept && m == START_BYTE) begin
                        for (int i = 0; i < 8; i++) r_h[i] <= IV[i];
                        hash_ready <= 1'b0;
                        r_state    <= ST_WAIT_BYTE;
`ifdef HASH_LEN_FINAL_EN
                        r_len      <= 8'h00;
`endif
                    end
                end

                ST_WAIT_BYTE: begin
                    if (w_accept) begin
                        if (m == START_BYTE) begin
                            // Restart the message from scratch.
                            for (int i = 0; i < 8; i++) r_h[i] <= IV[i];
`ifdef HASH_LEN_FINAL_EN
                            r_len <= 8'h00;
`endif
                        end else if (m == END_BYTE) begin
`ifdef HASH_LEN_FINAL_EN
                            r_b       <= r_len;
                            r_count   <= '0;
                            next_byte <= 1'b1;
                            r_final   <= 1'b1;
                            r_state   <= ST_ABSORB;
`else
                            out        <= w_h_packed;
                            hash_ready <= 1'b1;
                            r_state    <= ST_IDLE;
`endif
                        end else begin
                            r_b       <= m;
                            r_count   <= '0;
                            next_byte <= 1'b1;
                            r_state   <= ST_ABSORB;
`ifdef HASH_LEN_FINAL_EN
                            r_len     <= r_len + 8'd1;
`endif
                        end
                    end
                end

                ST_ABSORB: begin
                    for (int i = 0; i < 8; i++) r_h[i] <= w_h_next[i];
                    if (r_count == c_last) begin
                        r_count   <= '0;
                        next_byte <= 1'b0;
`ifdef HASH_LEN_FINAL_EN
                        r_state   <= r_final ? ST_IDLE : ST_WAIT_BYTE;
`else
                        r_state   <= ST_WAIT_BYTE;
`endif
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    next_byte <= 1'b0;
                end
            endcase
        end
    end

endmodule : hash
`default_nettype wire

// File: tb/tb_hash.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hash
//  Description : Self-checking bench for the hash engine. Digests are
//                predicted by a reference model that derives the S-box from
//                GF(2^8) inversion plus the affine map and applies the round
//                formula on plain arrays.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hash;
    import hash_pkg::*;

    localparam int R = 32;

    typedef logic [7:0] bq_t [$];

    logic        clk = 1'b0;
    logic        reset_l;
    logic [7:0]  m;
    logic        m_valid;
    logic        hash_ready;
    logic [63:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sref [0:255];

    hash #(.ROUNDS(R)) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .m          (m),
        .m_valid    (m_valid),
        .hash_ready (hash_ready),
        .out        (out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] brot(input logic [7:0] v, input int n);
        logic [7:0] t;
        t = v;
        for (int i = 0; i < n; i++) t = {t[6:0], t[7]};
        return t;
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sref[x] = inv ^ brot(inv, 1) ^ brot(inv, 2) ^ brot(inv, 3)
                          ^ brot(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [63:0] model_digest(input bq_t q);
        logic [7:0] h  [8];
        logic [7:0] nh [8];
        bq_t        seq;
        h   = '{8'h34, 8'h55, 8'h0F, 8'h14, 8'hAA, 8'h38, 8'h42, 8'h57};
        seq = q;
`ifdef HASH_LEN_FINAL_EN
        seq.push_back(8'(q.size()));
`endif
        foreach (seq[k]) begin
            for (int r = 0; r < R; r++) begin
                for (int i = 0; i < 8; i++)
                    nh[i] = h[i] ^ brot(sref[h[(i + 1) % 8] ^ seq[k] ^ 8'(r)], i);
                h = nh;
            end
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] v);
        @(negedge clk);
        m       = v;
        m_valid = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
    endtask

    task automatic wait_absorb();
        int k;
        k = 0;
        while (dut.next_byte === 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL absorb_timeout: next_byte still %b after %0d cycles, required 0",
                     dut.next_byte, k);
        end
    endtask

    // Terminate the frame and sample the result once it is due.
    task automatic finish_msg(output logic [63:0] d, output logic rdy);
        send(END_BYTE);
`ifdef HASH_LEN_FINAL_EN
        wait_absorb();
        @(negedge clk);
`endif
        rdy = hash_ready;
        d   = out;
    endtask

    task automatic run_msg(input bq_t q, output logic [63:0] d, output logic rdy);
        send(START_BYTE);
        foreach (q[i]) begin
            send(q[i]);
            wait_absorb();
        end
        finish_msg(d, rdy);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_l = 1'b1;
        m       = 8'h00;
        m_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_l = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (hash_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b, required 0", hash_ready);
        end
        n_checks++;
        if (out !== 64'h0) begin
            n_fail++; $display("FAIL reset_out: got %h, required 0", out);
        end
        n_checks++;
        if (dut.next_byte !== 1'b0) begin
            n_fail++; $display("FAIL reset_next_byte: got %b, required 0", dut.next_byte);
        end
        // Non-start bytes in IDLE are ignored.
        send(END_BYTE);
        send(8'h41);
        n_checks++;
        if (hash_ready !== 1'b0 || dut.next_byte !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore: ready=%b next_byte=%b, required 0/0",
                     hash_ready, dut.next_byte);
        end
    endtask

    task automatic test_empty();
        logic [63:0] d;
        logic        rdy;
        bq_t         q;
        q = {};
        run_msg(q, d, rdy);
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++; $display("FAIL empty_ready: got %b, required 1", rdy);
        end
        n_checks++;
        if (d !== model_digest(q)) begin
            n_fail++; $display("FAIL empty_digest: got %h, required %h", d, model_digest(q));
        end
`ifndef HASH_LEN_FINAL_EN
        n_checks++;
        if (d !== 64'h3455_0F14_AA38_4257) begin
            n_fail++; $display("FAIL empty_iv: got %h, required 34550f14aa384257", d);
        end
`endif
    endtask

    task automatic test_byte_window();
        logic [63:0] d;
        logic        rdy;
        int          k;
        send(START_BYTE);
        send(8'h41);
        k = 0;
        while (dut.next_byte === 1'b1 && k < 1000) begin
            if (k == 10) begin
                m       = 8'h42;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        m_valid = 1'b0;
        n_checks++;
        if (k !== R) begin
            n_fail++; $display("FAIL busy_window: next_byte high %0d cycles, required %0d", k, R);
        end
        finish_msg(d, rdy);
        n_checks++;
        if (rdy !== 1'b1 || d !== model_digest(str2q("A"))) begin
            n_fail++;
            $display("FAIL lost_byte_digest: ready=%b got %h, required 1 / %h",
                     rdy, d, model_digest(str2q("A")));
        end
    endtask

    task automatic test_repeat_and_differ();
        logic [63:0] d1, d2;
        logic        r1, r2;
        run_msg(str2q("Hello"), d1, r1);
        run_msg(str2q("Hello"), d2, r2);
        n_checks++;
        if (d1 !== d2 || d1 !== model_digest(str2q("Hello"))) begin
            n_fail++;
            $display("FAIL hello_repeat: got %h and %h, required %h",
                     d1, d2, model_digest(str2q("Hello")));
        end
        run_msg(str2q("World123456789"), d1, r1);
        run_msg(str2q("World123456780"), d2, r2);
        n_checks++;
        if (d1 === d2) begin
            n_fail++; $display("FAIL world_differ: both %h, required different digests", d1);
        end
        n_checks++;
        if (d2 !== model_digest(str2q("World123456780"))) begin
            n_fail++;
            $display("FAIL world_digest: got %h, required %h",
                     d2, model_digest(str2q("World123456780")));
        end
    endtask

    task automatic test_restart();
        logic [63:0] d;
        logic        rdy;
        send(START_BYTE);
        send(8'h61); wait_absorb();
        send(8'h62); wait_absorb();
        send(START_BYTE);
        n_checks++;
        if (hash_ready !== 1'b0) begin
            n_fail++; $display("FAIL restart_ready_a: got %b, required 0", hash_ready);
        end
        send(8'h61); wait_absorb();
        send(8'h62); wait_absorb();
        n_checks++;
        if (hash_ready !== 1'b0) begin
            n_fail++; $display("FAIL restart_ready_b: got %b, required 0", hash_ready);
        end
        finish_msg(d, rdy);
        n_checks++;
        if (rdy !== 1'b1 || d !== model_digest(str2q("ab"))) begin
            n_fail++;
            $display("FAIL restart_digest: ready=%b got %h, required 1 / %h",
                     rdy, d, model_digest(str2q("ab")));
        end
    endtask

    task automatic test_random();
        logic [63:0] d;
        logic        rdy;
        bq_t         q;
        for (int it = 0; it < 6; it++) begin
            q = {};
            for (int j = 0; j < int'($urandom_range(1, 5)); j++)
                q.push_back(8'($urandom_range(1, 254)));
            run_msg(q, d, rdy);
            n_checks++;
            if (rdy !== 1'b1 || d !== model_digest(q)) begin
                n_fail++;
                $display("FAIL random_digest[%0d]: ready=%b got %h, required 1 / %h",
                         it, rdy, d, model_digest(q));
            end
        end
    endtask

    task automatic test_hold();
        logic [63:0] d;
        logic        rdy;
        run_msg(str2q("xy"), d, rdy);
        send(START_BYTE);
        send(8'h33);
        wait_absorb();
        n_checks++;
        if (out !== model_digest(str2q("xy")) || hash_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_out: ready=%b got %h, required 0 / %h",
                     hash_ready, out, model_digest(str2q("xy")));
        end
        finish_msg(d, rdy);
    endtask

    task automatic test_async_reset();
        logic [63:0] d;
        logic        rdy;
        bq_t         q;
        send(START_BYTE);
        send(8'h5A);
        repeat (5) @(negedge clk);
        #2 reset_l = 1'b1;
        #1;
        n_checks++;
        if (hash_ready !== 1'b0 || out !== 64'h0 || dut.next_byte !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: ready=%b out=%h next_byte=%b, required 0/0/0",
                     hash_ready, out, dut.next_byte);
        end
        #1 reset_l = 1'b0;
        @(negedge clk);
        q = {};
        run_msg(q, d, rdy);
        n_checks++;
        if (rdy !== 1'b1 || d !== model_digest(q)) begin
            n_fail++;
            $display("FAIL post_reset_digest: ready=%b got %h, required 1 / %h",
                     rdy, d, model_digest(q));
        end
    endtask

    initial begin
        reset_l = 1'b1;
        m       = 8'h00;
        m_valid = 1'b0;
        build_sbox();
        test_reset();
        test_empty();
        test_byte_window();
        test_repeat_and_differ();
        test_restart();
        test_random();
        test_hold();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hash
`default_nettype wire
